timer_irq_dev: RTL and testbench

- Programmable countdown timer peripheral; the interrupt source that drives one bit of the coprocessor's HWInt[5:0] input.
- Sits on the CPU system bridge as a memory-mapped device: 4 word registers, 32-bit data.
- Counts down from a software-loaded preset and raises irq on expiry, in one-shot or auto-reload mode.

---
 rtl/timer_irq_pkg.sv | 28 ++
 rtl/timer_prescaler.sv | 33 +++
 rtl/timer_irq_dev.sv | 136 +++++++++++++
 tb/tb_timer_irq_dev.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/timer_irq_pkg.sv
// Shared constants and types for the timer_irq_dev countdown timer peripheral.
package timer_irq_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned CTRL_W = 4;

  localparam logic [ADDR_W-1:0] ADDR_CTRL   = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_PRESET = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_COUNT  = 2'd2;
  localparam logic [ADDR_W-1:0] ADDR_PSC    = 2'd3;

  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_MODE_LO = 1;
  localparam int unsigned CTRL_MODE_HI = 2;
  localparam int unsigned CTRL_IM      = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_e;

endpackage

// File: rtl/timer_prescaler.sv
// Prescale counter: tick_c fires when the counter matches psc, then the counter restarts at 0.
module timer_prescaler #(
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] psc,
  output logic                  tick_c
);

  logic [PRESCALE_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d  = cnt_q;
    tick_c = (cnt_q == psc);
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick_c ? '0 : PRESCALE_W'(cnt_q + PRESCALE_W'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/timer_irq_dev.sv
// Memory-mapped countdown timer with one-shot / auto-reload modes driving one HWInt bit.
// Optional prescaler on addr 3 compiled in with TIMER_IRQ_PRESCALE_EN.
module timer_irq_dev
  import timer_irq_pkg::*;
`ifdef TIMER_IRQ_PRESCALE_EN
#(
  parameter int unsigned PRESCALE_W = 8
)
`endif
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              irq
);

  state_e              state_q, state_d;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic [DATA_W-1:0]   preset_q, preset_d;
  logic [DATA_W-1:0]   count_q, count_d;
  logic                pending_q, pending_d;
  logic                irq_q, irq_d;
  logic                wr_ctrl_c, wr_preset_c, reload_c, tick_c;

  assign wr_ctrl_c   = we && (addr == ADDR_CTRL);
  assign wr_preset_c = we && (addr == ADDR_PRESET);
  assign reload_c    = (ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD);
  assign irq         = irq_q;

`ifdef TIMER_IRQ_PRESCALE_EN
  logic [PRESCALE_W-1:0] psc_q, psc_d;

  always_comb begin
    psc_d = psc_q;
    if (we && (addr == ADDR_PSC)) psc_d = din[PRESCALE_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) psc_q <= '0;
    else     psc_q <= psc_d;
  end

  timer_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .clr    (state_q == LOAD),
    .en     (state_q == CNT),
    .psc    (psc_q),
    .tick_c (tick_c)
  );
`else
  assign tick_c = 1'b1;
`endif

  // Next-state and register update; software writes are applied last so they win.
  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    preset_d  = preset_q;
    count_d   = count_q;
    pending_d = pending_q;
    case (state_q)
      IDLE: if (ctrl_q[CTRL_EN]) state_d = LOAD;
      LOAD: begin
        count_d = preset_q;
        state_d = CNT;
      end
      CNT: begin
        if (!ctrl_q[CTRL_EN]) begin
          state_d = IDLE;
        end else if (tick_c) begin
          if (count_q <= DATA_W'(1)) begin
            count_d = '0;
            state_d = INT;
          end else begin
            count_d = count_q - DATA_W'(1);
          end
        end
      end
      INT: begin
        if (reload_c) begin
          state_d = LOAD;
        end else begin
          ctrl_d[CTRL_EN] = 1'b0;
          pending_d       = 1'b1;
          state_d         = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (wr_ctrl_c)   ctrl_d   = din[CTRL_W-1:0];
    if (wr_preset_c) preset_d = din;
    if (wr_ctrl_c || wr_preset_c) pending_d = 1'b0;
    irq_d = ctrl_d[CTRL_IM] &
            (pending_d | ((state_d == INT) &&
                          (ctrl_d[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ctrl_q    <= '0;
      preset_q  <= '0;
      count_q   <= '0;
      pending_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      preset_q  <= preset_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      irq_q     <= irq_d;
    end
  end

  // Zero-latency read mux.
  always_comb begin
    dout = '0;
    case (addr)
      ADDR_CTRL:   dout = DATA_W'(ctrl_q);
      ADDR_PRESET: dout = preset_q;
      ADDR_COUNT:  dout = count_q;
`ifdef TIMER_IRQ_PRESCALE_EN
      ADDR_PSC:    dout = DATA_W'(psc_q);
`else
      ADDR_PSC:    dout = '0;
`endif
      default:     dout = '0;
    endcase
  end

endmodule

// File: tb/tb_timer_irq_dev.sv
// Directed self-checking bench for timer_irq_dev; define TIMER_IRQ_PRESCALE_EN to cover the prescaler.
module tb_timer_irq_dev;
  import timer_irq_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  timer_irq_dev dut (
    .clk  (clk),
    .rst  (rst),
    .addr (addr),
    .we   (we),
    .din  (din),
    .dout (dout),
    .irq  (irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) step();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr = a;
    din  = d;
    we   = 1'b1;
    step();
    we   = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(tag, dout, exp);
  endtask

  task automatic chk_irq(input string tag, input logic exp);
    check(tag, 32'(irq), 32'(exp));
  endtask

  initial begin
    rst  = 1'b1;
    we   = 1'b0;
    addr = 2'd0;
    din  = '0;
    cycles(2);
    rst = 1'b0;
    rd("rst_ctrl", ADDR_CTRL, 32'h0);
    rd("rst_preset", ADDR_PRESET, 32'h0);
    rd("rst_count", ADDR_COUNT, 32'h0);
    rd("rst_addr3", ADDR_PSC, 32'h0);
    chk_irq("rst_irq", 1'b0);

    // One-shot, PRESET=3: COUNT 3,2,1,0 then irq level 6 cycles after the CTRL edge.
    wr(ADDR_PRESET, 32'd3);
    wr(ADDR_CTRL, 32'h9);
    cycles(2); rd("os_cnt3", ADDR_COUNT, 32'd3);
    step();    rd("os_cnt2", ADDR_COUNT, 32'd2);
    step();    rd("os_cnt1", ADDR_COUNT, 32'd1);
    step();    rd("os_cnt0", ADDR_COUNT, 32'd0);
    chk_irq("os_irq_t5", 1'b0);
    step();    chk_irq("os_irq_t6", 1'b1);
    rd("os_ctrl_en_clr", ADDR_CTRL, 32'h8);
    step();    chk_irq("os_irq_hold", 1'b1);
    wr(ADDR_CTRL, 32'h8);
    chk_irq("os_irq_clr", 1'b0);

    // Auto-reload, PRESET=2: one-cycle pulse every 4 cycles, first at t+4.
    wr(ADDR_PRESET, 32'd2);
    wr(ADDR_CTRL, 32'hB);
    for (int k = 1; k <= 21; k++) begin
      step();
      chk_irq($sformatf("rl_irq_k%0d", k), (k >= 4) && (k % 4 == 0));
    end
    wr(ADDR_CTRL, 32'h0);
    step(); chk_irq("rl_stop_irq", 1'b0);

    // Disable mid-count, PRESET write during CNT, COUNT write ignored.
    wr(ADDR_PRESET, 32'd10);
    wr(ADDR_CTRL, 32'h9);
    cycles(7); rd("dis_cnt5", ADDR_COUNT, 32'd5);
    wr(ADDR_CTRL, 32'h0);
    rd("dis_cnt4", ADDR_COUNT, 32'd4);
    cycles(3); rd("dis_frozen", ADDR_COUNT, 32'd4);
    chk_irq("dis_irq", 1'b0);
    wr(ADDR_CTRL, 32'h1);
    cycles(2); rd("reen_cnt10", ADDR_COUNT, 32'd10);
    wr(ADDR_PRESET, 32'hFFFF_FFFF);
    rd("pre_wr_cnt9", ADDR_COUNT, 32'd9);
    step();    rd("pre_wr_cnt8", ADDR_COUNT, 32'd8);
    wr(ADDR_COUNT, 32'h1234);
    rd("cnt_wr_ign", ADDR_COUNT, 32'd7);
    wr(ADDR_CTRL, 32'h0);
    rd("stop_cnt6", ADDR_COUNT, 32'd6);
    step();    rd("stop_frozen", ADDR_COUNT, 32'd6);
    rd("preset_rb", ADDR_PRESET, 32'hFFFF_FFFF);

    // Masked one-shot: pending is set but irq stays low; a CTRL write clears pending.
    wr(ADDR_PRESET, 32'd1);
    wr(ADDR_CTRL, 32'h1);
    cycles(2); rd("im0_cnt1", ADDR_COUNT, 32'd1);
    step();    rd("im0_cnt0", ADDR_COUNT, 32'd0);
    chk_irq("im0_irq_int", 1'b0);
    step();    chk_irq("im0_irq_pend", 1'b0);
    rd("im0_ctrl", ADDR_CTRL, 32'h0);
    wr(ADDR_CTRL, 32'h8);
    chk_irq("im0_unmask", 1'b0);
    step();    chk_irq("im0_unmask2", 1'b0);

    // PRESET=0: INT after t+3, irq at t+4; a PRESET write clears pending.
    wr(ADDR_PRESET, 32'd0);
    wr(ADDR_CTRL, 32'h9);
    cycles(2); rd("p0_cnt", ADDR_COUNT, 32'd0);
    chk_irq("p0_irq_t2", 1'b0);
    step();    chk_irq("p0_irq_t3", 1'b0);
    step();    chk_irq("p0_irq_t4", 1'b1);
    rd("p0_ctrl", ADDR_CTRL, 32'h8);
    wr(ADDR_PRESET, 32'd5);
    chk_irq("p0_preset_clr", 1'b0);

    // Reset mid-count.
    wr(ADDR_PRESET, 32'd9);
    wr(ADDR_CTRL, 32'h9);
    cycles(6); rd("mr_cnt5", ADDR_COUNT, 32'd5);
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    rd("mr_ctrl", ADDR_CTRL, 32'h0);
    rd("mr_preset", ADDR_PRESET, 32'h0);
    rd("mr_count", ADDR_COUNT, 32'h0);
    rd("mr_addr3", ADDR_PSC, 32'h0);
    chk_irq("mr_irq", 1'b0);
    cycles(3); rd("mr_idle_cnt", ADDR_COUNT, 32'h0);
    chk_irq("mr_idle_irq", 1'b0);

`ifdef TIMER_IRQ_PRESCALE_EN
    wr(ADDR_PSC, 32'hFFFF_FFFF);
    rd("psc_rb_ff", ADDR_PSC, 32'hFF);
    wr(ADDR_PSC, 32'd2);
    rd("psc_rb_2", ADDR_PSC, 32'd2);
    // PSC=2, PRESET=2: COUNT steps every 3 cycles, irq 9 cycles after the CTRL edge.
    wr(ADDR_PRESET, 32'd2);
    wr(ADDR_CTRL, 32'h9);
    cycles(2); rd("psc_cnt2a", ADDR_COUNT, 32'd2);
    cycles(2); rd("psc_cnt2b", ADDR_COUNT, 32'd2);
    step();    rd("psc_cnt1", ADDR_COUNT, 32'd1);
    cycles(3); rd("psc_cnt0", ADDR_COUNT, 32'd0);
    chk_irq("psc_irq_t8", 1'b0);
    step();    chk_irq("psc_irq_t9", 1'b1);
`else
    wr(ADDR_PSC, 32'hFFFF_FFFF);
    rd("addr3_rd0", ADDR_PSC, 32'h0);
    rd("addr3_ctrl_keep", ADDR_CTRL, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
